// File: rtl/smart_bin_ctrl.sv
// Fill controller for one bin/tank: synchronises and debounces the level sensors,
// runs the pump with low/high hysteresis, times out stuck fills and counts completed fills.
`timescale 1ns/1ps
module smart_bin_ctrl #(
  parameter int CNT_BITS   = 8,
  parameter int DEB_CYCLES = 4,
  parameter int DONE_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 su,
  input  logic                 lh,
  input  logic                 ll,
  input  logic                 tick,
  input  logic [CNT_BITS-1:0]  limit,
  input  logic                 alarm_clr,
  output logic                 m,
  output logic                 fh,
  output logic                 fl,
  output logic                 a,
  output logic [1:0]           state,
  output logic [CNT_BITS-1:0]  fill_cnt,
  output logic [DONE_BITS-1:0] done_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FILL  = 2'b01,
    ST_FULL  = 2'b10,
    ST_FAULT = 2'b11
  } state_t;

  // Debounce counters are 8 bits wide, enough for the full 1..255 depth range.
  localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);

  logic r_su_s1, r_su_s2;
  logic r_lh_s1, r_lh_s2;
  logic r_ll_s1, r_ll_s2;
  logic r_lh_d, r_ll_d;
  logic [7:0] r_lh_cnt, r_ll_cnt;

  state_t                 r_state, w_state_nxt;
  logic [CNT_BITS-1:0]    r_fill;
  logic [DONE_BITS-1:0]   r_done;
  logic                   w_fill_clr, w_fill_inc, w_done_inc;
  logic                   w_incons, w_timeout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_su_s1 <= 1'b0;
      r_su_s2 <= 1'b0;
      r_lh_s1 <= 1'b0;
      r_lh_s2 <= 1'b0;
      r_ll_s1 <= 1'b0;
      r_ll_s2 <= 1'b0;
    end else begin
      r_su_s1 <= su;
      r_su_s2 <= r_su_s1;
      r_lh_s1 <= lh;
      r_lh_s2 <= r_lh_s1;
      r_ll_s1 <= ll;
      r_ll_s2 <= r_ll_s1;
    end
  end

  // A sensor change is accepted only after DEB_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lh_d   <= 1'b0;
      r_lh_cnt <= 8'd0;
    end else if (r_lh_s2 == r_lh_d) begin
      r_lh_cnt <= 8'd0;
    end else if (r_lh_cnt == DEB_LAST) begin
      r_lh_d   <= r_lh_s2;
      r_lh_cnt <= 8'd0;
    end else begin
      r_lh_cnt <= r_lh_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ll_d   <= 1'b0;
      r_ll_cnt <= 8'd0;
    end else if (r_ll_s2 == r_ll_d) begin
      r_ll_cnt <= 8'd0;
    end else if (r_ll_cnt == DEB_LAST) begin
      r_ll_d   <= r_ll_s2;
      r_ll_cnt <= 8'd0;
    end else begin
      r_ll_cnt <= r_ll_cnt + 8'd1;
    end
  end

  assign w_incons  = r_lh_d & ~r_ll_d;
  assign w_timeout = (r_state == ST_FILL) && (limit != '0) && (r_fill == limit);

  // Fault conditions pre-empt every normal move, so a tick or a full edge
  // coinciding with a timeout never touches the counters.
  always_comb begin
    w_state_nxt = r_state;
    w_fill_clr  = 1'b0;
    w_fill_inc  = 1'b0;
    w_done_inc  = 1'b0;
    if ((r_state != ST_FAULT) && w_incons) begin
      w_state_nxt = ST_FAULT;
    end else if (w_timeout) begin
      w_state_nxt = ST_FAULT;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_su_s2 && !r_ll_d) begin
            w_state_nxt = ST_FILL;
            w_fill_clr  = 1'b1;
          end else if (r_su_s2 && r_lh_d) begin
            w_state_nxt = ST_FULL;
          end
        end
        ST_FILL: begin
          if (r_lh_d) begin
            w_state_nxt = ST_FULL;
            w_done_inc  = 1'b1;
          end else if (!r_su_s2) begin
            w_state_nxt = ST_IDLE;
          end
          w_fill_inc = tick && (r_fill != '1);
        end
        ST_FULL: begin
          if (!r_su_s2) begin
            w_state_nxt = ST_IDLE;
          end else if (!r_ll_d) begin
            w_state_nxt = ST_FILL;
            w_fill_clr  = 1'b1;
          end
        end
        default: begin
          if (alarm_clr && !w_incons) begin
            w_state_nxt = ST_IDLE;
            w_fill_clr  = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_fill  <= '0;
      r_done  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_fill_clr) begin
        r_fill <= '0;
      end else if (w_fill_inc) begin
        r_fill <= r_fill + CNT_BITS'(1);
      end
      if (w_done_inc) begin
        r_done <= r_done + DONE_BITS'(1);
      end
    end
  end

  assign m        = (r_state == ST_FILL);
  assign a        = (r_state == ST_FAULT);
  assign fh       = r_lh_d;
  assign fl       = ~r_ll_d;
  assign state    = r_state;
  assign fill_cnt = r_fill;
  assign done_cnt = r_done;

endmodule

// File: tb/tb_smart_bin_ctrl.sv
// Self-checking bench for smart_bin_ctrl: directed scenarios plus a randomized run
// compared every cycle against a rule-level reference model.
`timescale 1ns/1ps
module tb_smart_bin_ctrl;

  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       su = 1'b0, lh = 1'b0, ll = 1'b0, tick = 1'b0, alarm_clr = 1'b0;
  logic [7:0] limit = 8'd0;
  logic       m, fh, fl, a;
  logic [1:0] state;
  logic [7:0] fill_cnt, done_cnt;

  int total = 0;
  int bad   = 0;

  // Reference model: sync delay lines, sample histories for debounce, rule-level FSM.
  logic mdl_su_p1, mdl_su_s, mdl_lh_p1, mdl_lh_s, mdl_ll_p1, mdl_ll_s;
  logic mdl_lh_d, mdl_ll_d;
  logic lh_hist[$];
  logic ll_hist[$];
  int   mdl_state, mdl_fill, mdl_done;

  smart_bin_ctrl #(.CNT_BITS(8), .DEB_CYCLES(DEB), .DONE_BITS(8)) dut (
    .clk(clk), .rst(rst), .su(su), .lh(lh), .ll(ll), .tick(tick),
    .limit(limit), .alarm_clr(alarm_clr), .m(m), .fh(fh), .fl(fl), .a(a),
    .state(state), .fill_cnt(fill_cnt), .done_cnt(done_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  function automatic bit all_differ(input logic q[$], input logic d);
    foreach (q[i]) if (q[i] == d) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    mdl_su_p1 = 0; mdl_su_s = 0; mdl_lh_p1 = 0; mdl_lh_s = 0; mdl_ll_p1 = 0; mdl_ll_s = 0;
    mdl_lh_d = 0; mdl_ll_d = 0;
    lh_hist.delete(); ll_hist.delete();
    mdl_state = 0; mdl_fill = 0; mdl_done = 0;
  endtask

  task automatic model_edge();
    bit incons;
    int n_state, n_fill, n_done;
    incons  = mdl_lh_d && !mdl_ll_d;
    n_state = mdl_state; n_fill = mdl_fill; n_done = mdl_done;
    if (mdl_state != 3 && incons) n_state = 3;
    else if (mdl_state == 1 && limit != 0 && mdl_fill == int'(limit)) n_state = 3;
    else if (mdl_state == 0) begin
      if (mdl_su_s && !mdl_ll_d) begin n_state = 1; n_fill = 0; end
      else if (mdl_su_s && mdl_lh_d) n_state = 2;
    end else if (mdl_state == 1) begin
      if (mdl_lh_d) begin n_state = 2; n_done = (mdl_done + 1) % 256; end
      else if (!mdl_su_s) n_state = 0;
      if (tick && mdl_fill < 255) n_fill = mdl_fill + 1;
    end else if (mdl_state == 2) begin
      if (!mdl_su_s) n_state = 0;
      else if (!mdl_ll_d) begin n_state = 1; n_fill = 0; end
    end else begin
      if (alarm_clr && !incons) begin n_state = 0; n_fill = 0; end
    end
    mdl_state = n_state; mdl_fill = n_fill; mdl_done = n_done;
    lh_hist.push_back(mdl_lh_s);
    if (lh_hist.size() > DEB) void'(lh_hist.pop_front());
    if (lh_hist.size() == DEB && all_differ(lh_hist, mdl_lh_d)) mdl_lh_d = ~mdl_lh_d;
    ll_hist.push_back(mdl_ll_s);
    if (ll_hist.size() > DEB) void'(ll_hist.pop_front());
    if (ll_hist.size() == DEB && all_differ(ll_hist, mdl_ll_d)) mdl_ll_d = ~mdl_ll_d;
    mdl_su_s = mdl_su_p1; mdl_su_p1 = su;
    mdl_lh_s = mdl_lh_p1; mdl_lh_p1 = lh;
    mdl_ll_s = mdl_ll_p1; mdl_ll_p1 = ll;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    su = 1; ll = 0; lh = 0; tick = 0; alarm_clr = 0; limit = 0;
    apply_reset();
    total++; if (state !== 2'b00) begin bad++; $display("FAIL reset_state: got %b want 00", state); end
    total++; if ({m, a, fh, fl} !== 4'b0001) begin bad++; $display("FAIL reset_flags: got m,a,fh,fl=%b want 0001", {m, a, fh, fl}); end
    total++; if (fill_cnt !== 8'd0 || done_cnt !== 8'd0) begin bad++; $display("FAIL reset_cnts: got fill=%0d done=%0d want 0 0", fill_cnt, done_cnt); end
    steps(2);
    total++; if (m !== 1'b0) begin bad++; $display("FAIL sync_delay_m: got %b want 0 at clock 2", m); end
    step();
    total++; if (state !== 2'b01 || m !== 1'b1) begin bad++; $display("FAIL start_fill: got state=%b m=%b want 01 1", state, m); end
  endtask

  task automatic test_fill_to_full();
    limit = 8'd20; tick = 1; ll = 1;
    steps(3);
    lh = 1;
    steps(2);
    total++; if (fl !== 1'b1) begin bad++; $display("FAIL ll_deb_early: got fl=%b want 1", fl); end
    step();
    total++; if (fl !== 1'b0) begin bad++; $display("FAIL ll_deb_latency: got fl=%b want 0", fl); end
    steps(2);
    total++; if (fh !== 1'b0) begin bad++; $display("FAIL lh_deb_early: got fh=%b want 0", fh); end
    step();
    total++; if (fh !== 1'b1 || state !== 2'b01) begin bad++; $display("FAIL lh_deb_latency: got fh=%b state=%b want 1 01", fh, state); end
    step();
    total++; if (state !== 2'b10 || m !== 1'b0) begin bad++; $display("FAIL full_entry: got state=%b m=%b want 10 0", state, m); end
    total++; if (done_cnt !== 8'd1 || fill_cnt !== 8'd10) begin bad++; $display("FAIL full_cnts: got done=%0d fill=%0d want 1 10", done_cnt, fill_cnt); end
    tick = 0;
    steps(3);
    total++; if (fill_cnt !== 8'd10) begin bad++; $display("FAIL fill_hold: got %0d want 10", fill_cnt); end
  endtask

  task automatic test_hysteresis();
    lh = 0;
    steps(6);
    total++; if (fh !== 1'b0 || state !== 2'b10 || m !== 1'b0) begin bad++; $display("FAIL hyst_band: got fh=%b state=%b m=%b want 0 10 0", fh, state, m); end
    ll = 0;
    steps(6);
    total++; if (fl !== 1'b1 || state !== 2'b10) begin bad++; $display("FAIL hyst_low_seen: got fl=%b state=%b want 1 10", fl, state); end
    step();
    total++; if (state !== 2'b01 || m !== 1'b1 || fill_cnt !== 8'd0) begin bad++; $display("FAIL refill: got state=%b m=%b fill=%0d want 01 1 0", state, m, fill_cnt); end
  endtask

  task automatic test_timeout();
    limit = 8'd5; tick = 1;
    steps(5);
    total++; if (state !== 2'b01 || fill_cnt !== 8'd5) begin bad++; $display("FAIL timeout_pre: got state=%b fill=%0d want 01 5", state, fill_cnt); end
    step();
    total++; if (state !== 2'b11 || a !== 1'b1 || m !== 1'b0 || fill_cnt !== 8'd5) begin bad++; $display("FAIL timeout_fault: got state=%b a=%b m=%b fill=%0d want 11 1 0 5", state, a, m, fill_cnt); end
    tick = 0; alarm_clr = 1;
    step();
    total++; if (state !== 2'b00 || a !== 1'b0 || fill_cnt !== 8'd0) begin bad++; $display("FAIL alarm_clr: got state=%b a=%b fill=%0d want 00 0 0", state, a, fill_cnt); end
    alarm_clr = 0;
    step();
    total++; if (state !== 2'b01 || fill_cnt !== 8'd0) begin bad++; $display("FAIL refill_after_fault: got state=%b fill=%0d want 01 0", state, fill_cnt); end
  endtask

  task automatic test_debounce();
    limit = 0; tick = 0; lh = 1;
    steps(3);
    lh = 0;
    steps(10);
    total++; if (fh !== 1'b0 || state !== 2'b01) begin bad++; $display("FAIL glitch_ignored: got fh=%b state=%b want 0 01", fh, state); end
    lh = 1;
    steps(5);
    total++; if (fh !== 1'b0) begin bad++; $display("FAIL lh_stable_early: got fh=%b want 0", fh); end
    step();
    total++; if (fh !== 1'b1) begin bad++; $display("FAIL lh_stable_accept: got fh=%b want 1", fh); end
    step();
    total++; if (state !== 2'b11 || a !== 1'b1 || done_cnt !== 8'd1) begin bad++; $display("FAIL incons_fault: got state=%b a=%b done=%0d want 11 1 1", state, a, done_cnt); end
    alarm_clr = 1;
    steps(2);
    total++; if (state !== 2'b11) begin bad++; $display("FAIL clr_ignored: got state=%b want 11", state); end
    alarm_clr = 0; ll = 1;
    steps(6);
    total++; if (fl !== 1'b0 || state !== 2'b11) begin bad++; $display("FAIL fault_held: got fl=%b state=%b want 0 11", fl, state); end
    alarm_clr = 1;
    step();
    total++; if (state !== 2'b00) begin bad++; $display("FAIL clr_accepted: got state=%b want 00", state); end
    alarm_clr = 0;
    step();
    total++; if (state !== 2'b10 || done_cnt !== 8'd1) begin bad++; $display("FAIL idle_to_full: got state=%b done=%0d want 10 1", state, done_cnt); end
  endtask

  task automatic test_saturation();
    lh = 0; ll = 0;
    steps(7);
    total++; if (state !== 2'b01 || fill_cnt !== 8'd0) begin bad++; $display("FAIL sat_start: got state=%b fill=%0d want 01 0", state, fill_cnt); end
    limit = 0; tick = 1;
    steps(300);
    total++; if (state !== 2'b01 || fill_cnt !== 8'd255) begin bad++; $display("FAIL saturate: got state=%b fill=%0d want 01 255", state, fill_cnt); end
    tick = 0;
  endtask

  task automatic test_done_wrap();
    int exp_done;
    int n;
    exp_done = 1;
    for (int i = 0; i < 256; i++) begin
      lh = 1; ll = 1; n = 0;
      while (state !== 2'b10 && n < 20) begin step(); n++; end
      exp_done = (exp_done + 1) % 256;
      total++; if (state !== 2'b10 || done_cnt !== exp_done[7:0]) begin bad++; $display("FAIL wrap_full_%0d: got state=%b done=%0d want 10 %0d", i, state, done_cnt, exp_done); end
      lh = 0; ll = 0; n = 0;
      while (state !== 2'b01 && n < 20) begin step(); n++; end
      if (state !== 2'b01) begin total++; bad++; $display("FAIL wrap_refill_%0d: got state=%b want 01", i, state); end
    end
    total++; if (done_cnt !== 8'd1) begin bad++; $display("FAIL done_wrapped: got %0d want 1", done_cnt); end
  endtask

  task automatic test_async_reset();
    total++; if (m !== 1'b1) begin bad++; $display("FAIL pre_reset_m: got %b want 1", m); end
    #2;
    rst = 1'b1;
    #1;
    total++; if (m !== 1'b0 || state !== 2'b00 || done_cnt !== 8'd0 || fill_cnt !== 8'd0) begin bad++; $display("FAIL async_reset: got m=%b state=%b done=%0d fill=%0d want 0 00 0 0", m, state, done_cnt, fill_cnt); end
    @(posedge clk);
    #1;
    model_reset();
    rst = 1'b0;
  endtask

  task automatic test_random();
    int hold;
    logic [1:0] exp_st;
    hold = 0;
    apply_reset();
    for (int c = 0; c < 1500; c++) begin
      if (c % 250 == 0) limit = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(3, 40));
      if (hold == 0) begin
        su = ($urandom_range(0, 7) != 0);
        lh = 1'($urandom_range(0, 1));
        ll = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 12);
      end
      hold--;
      tick = 1'($urandom_range(0, 1));
      alarm_clr = ($urandom_range(0, 15) == 0);
      step();
      exp_st = mdl_state[1:0];
      total++;
      if ({state, m, a, fh, fl} !== {exp_st, exp_st == 2'b01, exp_st == 2'b11, mdl_lh_d, ~mdl_ll_d}) begin
        bad++; $display("FAIL rnd_state_c%0d: got st,m,a,fh,fl=%b want %b", c, {state, m, a, fh, fl}, {exp_st, exp_st == 2'b01, exp_st == 2'b11, mdl_lh_d, ~mdl_ll_d});
      end
      total++;
      if (fill_cnt !== mdl_fill[7:0] || done_cnt !== mdl_done[7:0]) begin
        bad++; $display("FAIL rnd_cnts_c%0d: got fill=%0d done=%0d want %0d %0d", c, fill_cnt, done_cnt, mdl_fill, mdl_done);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fill_to_full();
    test_hysteresis();
    test_timeout();
    test_debounce();
    test_saturation();
    test_done_wrap();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
